// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the zero-register index and the data type for the write-back stage
package wb_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int REG_AW_DEF = 5;
  localparam int XZR_IDX = 31;
  typedef logic [DATA_W_DEF-1:0] wb_data_t;
endpackage

// File: rtl/wb_if.sv
// wb_if: write-back bus; master drives stall/rd_in/mem_data/alu_result/mem_to_reg/reg_write_in, slave drives wr_data/wr_reg/wr_en
interface wb_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);
  logic stall;
  logic [REG_AW-1:0] rd_in;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_result;
  logic mem_to_reg;
  logic reg_write_in;
  logic [DATA_W-1:0] wr_data;
  logic [REG_AW-1:0] wr_reg;
  logic wr_en;
  modport master (
    output stall, rd_in, mem_data, alu_result, mem_to_reg, reg_write_in,
    input wr_data, wr_reg, wr_en
  );
  modport slave (
    input stall, rd_in, mem_data, alu_result, mem_to_reg, reg_write_in,
    output wr_data, wr_reg, wr_en
  );
endinterface

// File: rtl/wb_mux.sv
// wb_mux: combinational 2:1 select; sel=1 picks mem_data, sel=0 picks alu_result, output y
module wb_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] y
);
  always_comb y = sel ? mem_data : alu_result;
endmodule

// File: rtl/write_back.sv
// write_back: registered write-back stage (clk, rst sync active-high, bus: wb_if.slave); WB_ZERO_REG_SUPPRESS_EN drops wr_en for writes to register 31
module write_back
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  logic [DATA_W-1:0] sel_data;
  logic we;
  wb_mux #(.DATA_W(DATA_W)) u_mux (
    .sel(bus.mem_to_reg),
    .mem_data(bus.mem_data),
    .alu_result(bus.alu_result),
    .y(sel_data)
  );
`ifdef WB_ZERO_REG_SUPPRESS_EN
  always_comb we = bus.reg_write_in && (bus.rd_in != REG_AW'(XZR_IDX));
`else
  always_comb we = bus.reg_write_in;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      bus.wr_data <= '0;
      bus.wr_reg <= '0;
      bus.wr_en <= 1'b0;
    end else if (!bus.stall) begin
      bus.wr_data <= sel_data;
      bus.wr_reg <= bus.rd_in;
      bus.wr_en <= we;
    end
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: scoreboard bench for write_back
module tb_write_back;
  import wb_pkg::*;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  r;
    logic        e;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  exp_t q[$];
  exp_t model = '0;
  wb_if #(.DATA_W(64), .REG_AW(5)) bus ();
  write_back #(.DATA_W(64), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic s, input logic [4:0] rd,
                      input logic [63:0] mem, input logic [63:0] alu, input logic m2r, input logic rw);
    exp_t got;
    exp_t e;
    rst = r;
    bus.stall = s;
    bus.rd_in = rd;
    bus.mem_data = mem;
    bus.alu_result = alu;
    bus.mem_to_reg = m2r;
    bus.reg_write_in = rw;
    if (r) model = '0;
    else if (!s) begin
      model.d = m2r ? mem : alu;
      model.r = rd;
`ifdef WB_ZERO_REG_SUPPRESS_EN
      model.e = rw && (rd != 5'd31);
`else
      model.e = rw;
`endif
    end
    q.push_back(model);
    @(posedge clk);
    #1;
    e = q.pop_front();
    got = '{d: bus.wr_data, r: bus.wr_reg, e: bus.wr_en};
    check({tag, ".data"}, got.d, e.d);
    check({tag, ".reg"}, 64'(got.r), 64'(e.r));
    check({tag, ".en"}, 64'(got.e), 64'(e.e));
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.rd_in = '0;
    bus.mem_data = '0;
    bus.alu_result = '0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write_in = 1'b0;
    @(negedge clk);
    step("rst0", 1, 0, 5'd6, 64'h1, 64'h2, 0, 1);
    step("rst1", 1, 0, 5'd6, 64'h1, 64'h2, 0, 1);
    step("alu", 0, 0, 5'd3, 64'hFFFF, 64'hA5, 0, 1);
    step("mem", 0, 0, 5'd9, 64'hDEAD_BEEF_0123_4567, 64'h10, 1, 1);
    step("ld11", 0, 0, 5'd4, 64'h11, 64'h99, 1, 1);
    step("stall0", 0, 1, 5'd7, 64'h22, 64'h33, 1, 1);
    step("stall1", 0, 1, 5'd7, 64'h22, 64'h33, 1, 1);
    step("stall2", 0, 1, 5'd7, 64'h22, 64'h33, 1, 1);
    step("unstall", 0, 0, 5'd7, 64'h22, 64'h33, 1, 1);
    step("nowr", 0, 0, 5'd12, 64'h5, 64'hCAFE, 0, 0);
    step("xzr", 0, 0, 5'd31, 64'h0, 64'h5, 0, 1);
    step("r30", 0, 0, 5'd30, 64'h0, 64'h6, 0, 1);
    step("xin", 0, 0, 5'd2, 64'h77, 64'bx, 1, 1);
    step("rststall", 1, 1, 5'd8, 64'h44, 64'h55, 1, 1);
    step("norplay", 0, 1, 5'd8, 64'h44, 64'h55, 1, 1);
    for (int i = 0; i < 40; i++)
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 5'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter DATA_W, default 64: width of the write-back data path.
REQ-002 Parameter REG_AW, default 5: width of the register-file address.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  when high, the stage holds its registered outputs.
REQ-007 rd_in  in  REG_AW  destination register field (instruction bits 4:0).
REQ-008 mem_data  in  DATA_W  data loaded from data memory.
REQ-009 alu_result  in  DATA_W  ALU result or effective address.
REQ-010 mem_to_reg  in  1  1 selects mem_data, 0 selects alu_result.
REQ-011 reg_write_in  in  1  register-write request from control.
REQ-012 wr_data  out  DATA_W  data for the register-file write port.
REQ-013 wr_reg  out  REG_AW  register-file write address.
REQ-014 wr_en  out  1  register-file write enable.

Function
REQ-015 Selection: sel_data = mem_to_reg ? mem_data : alu_result; full DATA_W width, no extension or truncation.
REQ-016 Latency: on each rising clk with rst=0 and stall=0, wr_data<=sel_data, wr_reg<=rd_in, wr_en<=reg_write_in (subject to REQ-024); one cycle from inputs to outputs.
REQ-017 Stall: with stall=1 and rst=0, all three outputs hold their previous values.
REQ-018 When reg_write_in=0, wr_data and wr_reg still update per REQ-016; only wr_en is 0.
REQ-019 Outputs come only from registers; there is no combinational path from any input to any output.
REQ-020 mem_to_reg is honoured regardless of reg_write_in; X on unselected data inputs does not propagate to wr_data.

Reset
REQ-021 rst=1 at a rising clk sets wr_data=0, wr_reg=0, wr_en=0.
REQ-022 rst has priority over stall and over all data inputs.
REQ-023 An input presented in the reset cycle is discarded, not replayed afterwards.

Configuration
REQ-024 Macro WB_ZERO_REG_SUPPRESS_EN: when defined, a write whose rd_in equals 31 (XZR) registers wr_en=0 while wr_data and wr_reg still update; when undefined, register 31 is written like any other register.

Structure
REQ-025 Package wb_pkg holds DATA_W_DEF=64, REG_AW_DEF=5, XZR_IDX=31 and a typedef wb_data_t (logic [DATA_W-1:0]).
REQ-026 Sub-module wb_mux is the combinational 2:1 data select of REQ-015; write_back instantiates it once and holds the output registers, stall and reset logic.

Verification
REQ-027 rst=1 for 2 cycles, then release -> wr_data=0, wr_reg=0, wr_en=0 after the first rst edge.
REQ-028 mem_to_reg=0, alu_result=0x0000_0000_0000_00A5, rd_in=3, reg_write_in=1 -> next cycle wr_data=0xA5, wr_reg=3, wr_en=1.
REQ-029 mem_to_reg=1, mem_data=0xDEAD_BEEF_0123_4567, alu_result=0x10, rd_in=9, reg_write_in=1 -> next cycle wr_data=0xDEAD_BEEF_0123_4567, wr_reg=9, wr_en=1.
REQ-030 Load result 0x11 to rd_in=4, then stall=1 for 3 cycles while inputs change to 0x22 and rd_in=7 -> outputs stay 0x11/4/1; on stall release they become 0x22/7.
REQ-031 rd_in=31, reg_write_in=1, alu_result=0x5 -> wr_en=0 with WB_ZERO_REG_SUPPRESS_EN defined, wr_en=1 without it; wr_data=0x5 and wr_reg=31 in both builds.
REQ-032 rst=1 asserted together with stall=1 and valid inputs -> all outputs 0 at that edge.
